cdc_sync_bank: RTL
==================

# cdc_sync_bank

Parametrised multi-channel synchroniser bank that brings CH asynchronous single-bit level signals into the clk_b domain. Each channel has a configurable flop chain, a per-channel edge detector (rising, falling, both, or off), and a saturating per-channel event counter. An optional glitch filter can be compiled in. The bank sits at the camera-interface boundary and collects the strobe, trigger and status lines that arrive from foreign clock domains or from pins.

## Interface
Parameters:
- CH, 4, number of independent channels (≥1)
- STAGES, 2, synchroniser flops per channel (≥2); every flop in the chain carries ASYNC_REG
- FILT_LEN, 4, consecutive stable cycles required by the glitch filter (≥1; used only with CDC_SYNC_FILTER_EN)
- CNT_W, 16, event counter width per channel

Ports:
- clk_b  input  1  destination clock
- rst_b  input  1  reset; asynchronous, active-high; clock clk_b
- sig_in  input  CH  asynchronous level inputs; bit i is channel i
- edge_mode  input  2*CH  per-channel edge select, quasi-static, clk_b domain: 00 off, 01 rising, 10 falling, 11 both
- cnt_clr  input  CH  synchronous per-channel event-counter clear
- sig_sync  output  CH  synchronised level (filtered if the filter is enabled)
- pulse_sync  output  CH  one-cycle registered pulse on each selected edge of sig_sync
- evt_cnt  output  CH*CNT_W  per-channel event counters; channel i occupies bits [i*CNT_W +: CNT_W]

## Operation
- Chain: sig_in[i] feeds STAGES flops. chain_out[i] is the last flop.
- Without the filter, sig_sync[i] = chain_out[i]. This is a direct assign, with no extra register.
- Edge detect: a register sig_d[i] holds the previous sig_sync[i].
  - rise = sig_sync & ~sig_d; fall = ~sig_sync & sig_d.
  - pulse_sync[i] is registered: (mode[0] & rise) | (mode[1] & fall).
  - With edge_mode 00, pulse_sync stays 0.
  - A change of edge_mode takes effect on the next clk_b edge. It never creates a pulse by itself.
- Counter: evt_cnt[i] increments by 1 on each cycle where pulse_sync[i] = 1.
  - It saturates at 2^CNT_W−1 and never wraps.
  - cnt_clr[i] sets the counter to 0. If cnt_clr[i] and pulse_sync[i] are both 1 in the same cycle, clear wins and that event is dropped.
- Channels are fully independent. There is no cross-channel coherence, so multi-bit buses must not be passed through this block.
- Reset: every flop goes to 0, so sig_sync = 0, pulse_sync = 0 and evt_cnt = 0.
  - If sig_in is high at reset release, sig_sync rises after the chain latency and a rising pulse is generated if enabled. This is intended behaviour.
  - An rst_b assertion in mid-operation clears the chain, the filter and the counters immediately.

## Timing
- Without the filter, for an input transition captured at clk_b edge k:
  - sig_sync changes after edge k+STAGES−1.
  - pulse_sync is high for exactly the one cycle after edge k+STAGES.
  - evt_cnt updates after edge k+STAGES+1.
- The filter adds FILT_LEN cycles to the sig_sync, pulse_sync and evt_cnt latencies.
- An input pulse shorter than one clk_b period may be missed. This is acceptable and documented for users.
- Back-to-back toggles of sig_sync on consecutive cycles give pulse_sync high on consecutive cycles when edge_mode = 11.

## Configuration
- CDC_SYNC_FILTER_EN defined: each channel gets a filtered register filt[i] and a counter of width clog2(FILT_LEN+1).
  - While chain_out ≠ filt, the counter increments each cycle.
  - When the counter reaches FILT_LEN−1 and chain_out ≠ filt, filt is loaded with chain_out and the counter returns to 0.
  - Whenever chain_out = filt, the counter returns to 0.
  - sig_sync = filt.
  - A glitch lasting fewer than FILT_LEN cycles at chain_out is suppressed.
- CDC_SYNC_FILTER_EN undefined: no filter logic is generated, and FILT_LEN is ignored.

## Structure
- Package cdc_sync_pkg holds:
  - the enum edge_mode_e (EDGE_OFF = 2'b00, EDGE_RISE, EDGE_FALL, EDGE_BOTH);
  - the localparam MIN_STAGES = 2;
  - an elaboration check that STAGES ≥ MIN_STAGES.
- Sub-module cdc_sync_chan implements one channel: chain, optional filter, edge detect and counter. The top level generates CH instances and packs the output buses.

## Test plan
- Reset and level: CH=4, STAGES=2, sig_in=4'b0101 held, all edge_mode=01. Expect sig_sync=0101 after 2 edges and evt_cnt of channels 0 and 2 = 1. Asserting rst_b mid-run must zero all outputs asynchronously.
- Edge modes: channel 1 toggles 0→1→0 with edge_mode=01, 10, 11 and 00 in turn. Expect 1, 1, 2 and 0 pulses respectively, each exactly one cycle wide.
- Saturation and clear: CNT_W=3, drive 10 rising edges. evt_cnt must stop at 7. Then assert cnt_clr together with a pulse: the counter reads 0, not 1.
- Latency: STAGES=3, with a single step captured at edge k. pulse_sync must be high only in the cycle after edge k+3.
- Filter (CDC_SYNC_FILTER_EN, FILT_LEN=4):
  - A 3-cycle glitch gives no sig_sync change and no pulse.
  - A 4-cycle-stable change updates sig_sync 4 cycles after chain_out and produces one pulse.
- Independence: random async toggles on all channels against a reference model. Per-channel pulse counts must match, with no cross-channel interaction.

Source files
------------

// File: rtl/cdc_sync_pkg.sv
// Shared types and elaboration helpers for the cdc_sync_bank synchroniser bank.
//   edge_mode_e : per-channel edge select encoding (off / rising / falling / both)
//   MIN_STAGES  : shortest flop chain accepted for metastability settling
//   stages_ok() : elaboration-time check applied by each channel instance
package cdc_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int unsigned MIN_STAGES = 2;

  function automatic bit stages_ok(input int unsigned stages);
    return stages >= MIN_STAGES;
  endfunction

endpackage

// File: rtl/cdc_sync_bank_if.sv
// Bus bundle for cdc_sync_bank.
//   sig_in     : CH asynchronous level inputs, bit i is channel i
//   edge_mode  : 2 bits per channel, quasi-static, clk_b domain
//   cnt_clr    : per-channel synchronous event-counter clear
//   sig_sync   : synchronised (optionally filtered) levels
//   pulse_sync : one-cycle pulse per selected edge of sig_sync
//   evt_cnt    : per-channel saturating counters, channel i at [i*CNT_W +: CNT_W]
// master drives the inputs and observes the results; slave is the bank.
interface cdc_sync_bank_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 16
);

  logic [CH-1:0]       sig_in;
  logic [2*CH-1:0]     edge_mode;
  logic [CH-1:0]       cnt_clr;
  logic [CH-1:0]       sig_sync;
  logic [CH-1:0]       pulse_sync;
  logic [CH*CNT_W-1:0] evt_cnt;

  modport master (
    output sig_in, edge_mode, cnt_clr,
    input  sig_sync, pulse_sync, evt_cnt
  );

  modport slave (
    input  sig_in, edge_mode, cnt_clr,
    output sig_sync, pulse_sync, evt_cnt
  );

endinterface

// File: rtl/cdc_sync_chan.sv
// One synchroniser channel: STAGES-deep flop chain, optional glitch filter,
// edge detector with registered pulse, and saturating event counter.
// Compile-time option: CDC_SYNC_FILTER_EN adds the FILT_LEN-cycle glitch filter.
//   clk_b, rst_b : destination clock, asynchronous active-high reset
//   sig_in       : asynchronous level input
//   mode         : edge select (edge_mode_e encoding)
//   cnt_clr      : synchronous counter clear, takes priority over a pulse
//   sig_sync     : synchronised level
//   pulse_sync   : registered one-cycle edge pulse
//   evt_cnt      : saturating event count
module cdc_sync_chan
  import cdc_sync_pkg::*;
#(
  parameter int unsigned STAGES   = 2,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_b,
  input  logic             rst_b,
  input  logic             sig_in,
  input  logic [1:0]       mode,
  input  logic             cnt_clr,
  output logic             sig_sync,
  output logic             pulse_sync,
  output logic [CNT_W-1:0] evt_cnt
);

  if (!stages_ok(STAGES) || FILT_LEN < 1) begin : g_param_err
    $error("cdc_sync_chan: STAGES must be >= MIN_STAGES and FILT_LEN >= 1");
  end

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;
  logic chain_out;

  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) chain <= '0;
    else       chain <= {chain[STAGES-2:0], sig_in};
  end

  assign chain_out = chain[STAGES-1];

`ifdef CDC_SYNC_FILTER_EN
  localparam int unsigned FW = $clog2(FILT_LEN + 1);

  logic          filt;
  logic [FW-1:0] fcnt;

  // fcnt counts consecutive cycles of disagreement; filt only follows
  // chain_out once it has disagreed for FILT_LEN cycles in a row.
  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (chain_out != filt) begin
      if (fcnt == FW'(FILT_LEN - 1)) begin
        filt <= chain_out;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end else begin
      fcnt <= '0;
    end
  end

  assign sig_sync = filt;
`else
  assign sig_sync = chain_out;
`endif

  logic sig_d;
  logic rise, fall, pulse_nxt;

  assign rise = sig_sync & ~sig_d;
  assign fall = ~sig_sync & sig_d;

  // Mode only gates edges already seen on sig_sync, so a mode change alone
  // can never produce a pulse.
  always_comb begin
    pulse_nxt = 1'b0;
    unique case (edge_mode_e'(mode))
      EDGE_RISE: pulse_nxt = rise;
      EDGE_FALL: pulse_nxt = fall;
      EDGE_BOTH: pulse_nxt = rise | fall;
      default:   pulse_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      sig_d      <= 1'b0;
      pulse_sync <= 1'b0;
    end else begin
      sig_d      <= sig_sync;
      pulse_sync <= pulse_nxt;
    end
  end

  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      evt_cnt <= '0;
    end else if (cnt_clr) begin
      evt_cnt <= '0;
    end else if (pulse_sync && (evt_cnt != '1)) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cdc_sync_bank.sv
// Multi-channel synchroniser bank bringing CH asynchronous single-bit levels
// into the clk_b domain with per-channel edge pulses and event counters.
// Channels are independent; do not pass multi-bit buses through this block.
// Compile-time option: CDC_SYNC_FILTER_EN enables the per-channel glitch filter.
//   clk_b : destination clock
//   rst_b : asynchronous active-high reset
//   bus   : cdc_sync_bank_if slave (sig_in, edge_mode, cnt_clr in;
//           sig_sync, pulse_sync, evt_cnt out)
module cdc_sync_bank
  import cdc_sync_pkg::*;
#(
  parameter int unsigned CH       = 4,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk_b,
  input  logic           rst_b,
  cdc_sync_bank_if.slave bus
);

  logic [CH-1:0]       sig_sync_v;
  logic [CH-1:0]       pulse_sync_v;
  logic [CH*CNT_W-1:0] evt_cnt_v;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    cdc_sync_chan #(
      .STAGES   (STAGES),
      .FILT_LEN (FILT_LEN),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk_b      (clk_b),
      .rst_b      (rst_b),
      .sig_in     (bus.sig_in[i]),
      .mode       (bus.edge_mode[2*i +: 2]),
      .cnt_clr    (bus.cnt_clr[i]),
      .sig_sync   (sig_sync_v[i]),
      .pulse_sync (pulse_sync_v[i]),
      .evt_cnt    (evt_cnt_v[i*CNT_W +: CNT_W])
    );
  end

  assign bus.sig_sync   = sig_sync_v;
  assign bus.pulse_sync = pulse_sync_v;
  assign bus.evt_cnt    = evt_cnt_v;

endmodule
